// File: rtl/lpc_dram_pkg.sv
// Shared definitions for the LPC DDR3 stream writer and read master:
// CSR map, FSM encoding and datapath widths.
package lpc_dram_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned ADDR_W   = 16;

    localparam logic [2:0] CSR_BASE      = 3'h0;
    localparam logic [2:0] CSR_LENGTH    = 3'h1;
    localparam logic [2:0] CSR_STEP      = 3'h2;
    localparam logic [2:0] CSR_DELIVERED = 3'h3;
    localparam logic [2:0] CSR_START     = 3'h4;
    localparam logic [2:0] CSR_DONE      = 3'h5;
    localparam logic [2:0] CSR_SRESET    = 3'h6;

    localparam logic [15:0] CSR_DEAD = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO; head is valid whenever empty is low.
module sample_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A pop frees the slot a push in the same cycle needs, so full does not block it.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/read_master.sv
// Avalon-MM read master: fetches a programmed block of samples from DDR3 and
// streams them out through a credit-limited FIFO.
module read_master
    import lpc_dram_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          csr_addr,
    input  logic                csr_read,
    input  logic                csr_write,
    input  logic [15:0]         csr_writedata,
    output logic [15:0]         csr_readdata,
    output logic [ADDR_W-1:0]   ddr_addr,
    output logic                ddr_read,
    input  logic                ddr_waitrequest,
    input  logic [SAMPLE_W-1:0] ddr_readdata,
    input  logic                ddr_readdatavalid,
    output logic [SAMPLE_W-1:0] s_data,
    output logic                s_valid,
    input  logic                s_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = FIFO_DEPTH[CW:0];

    state_t        state;
    state_t        state_next;
    logic [15:0]   base;
    logic [15:0]   length;
    logic [15:0]   step;
    logic [15:0]   delivered;
    logic [15:0]   issued;
    logic [CW-1:0] pending;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          srst;
    logic          busy;
    logic          start;
    logic          credit_ok;
    logic          accept;
    logic          push;
    logic          pop;

    // Soft reset is folded into the synchronous reset so both clear identically.
    assign srst      = reset || (csr_write && csr_addr == CSR_SRESET);
    assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign start     = csr_write && csr_addr == CSR_START && !busy;
    assign credit_ok = ({1'b0, pending} + {1'b0, fifo_count}) < CREDIT_LIMIT;
    assign ddr_read  = (state == ST_ISSUE) && (issued < length) && credit_ok;
    assign accept    = ddr_read && !ddr_waitrequest;
    assign push      = ddr_readdatavalid && busy;
    assign s_valid   = !fifo_empty;
    assign pop       = s_valid && s_ready;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (length == '0) begin
                    state_next = ST_DONE;
                end else if (issued == length || (accept && issued + 16'd1 == length)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pending == '0 && fifo_empty) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state        <= ST_IDLE;
            base         <= '0;
            length       <= '0;
            step         <= 16'd1;
            delivered    <= '0;
            issued       <= '0;
            pending      <= '0;
            ddr_addr     <= '0;
            csr_readdata <= '0;
        end else begin
            state <= state_next;
            if (csr_write && !busy) begin
                case (csr_addr)
                    CSR_BASE:   base   <= csr_writedata;
                    CSR_LENGTH: length <= csr_writedata;
                    CSR_STEP:   step   <= csr_writedata;
                    default:    ;
                endcase
            end
            if (start) begin
                ddr_addr  <= base;
                issued    <= '0;
                pending   <= '0;
                delivered <= '0;
            end else begin
                if (accept) begin
                    ddr_addr <= ddr_addr + step;
                    issued   <= issued + 16'd1;
                end
                case ({accept, push})
                    2'b10:   pending <= pending + 1'b1;
                    2'b01:   pending <= pending - 1'b1;
                    default: pending <= pending;
                endcase
                if (pop) delivered <= delivered + 16'd1;
            end
            if (csr_read) begin
                case (csr_addr)
                    CSR_BASE:      csr_readdata <= base;
                    CSR_LENGTH:    csr_readdata <= length;
                    CSR_STEP:      csr_readdata <= step;
                    CSR_DELIVERED: csr_readdata <= delivered;
                    CSR_DONE:      csr_readdata <= {15'd0, state == ST_DONE};
                    3'h7:          csr_readdata <= CSR_DEAD;
                    default:       csr_readdata <= '0;
                endcase
            end
        end
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (srst),
        .push      (push),
        .push_data (ddr_readdata),
        .pop       (pop),
        .head      (s_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
